// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction prefetch front-end: FSM encoding,
// queue entry layout and the default boot address.
package mips_fetch_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    localparam int ENTRY_W = 64;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Bundles the redirect, instruction-memory and decode-side signals of the
// prefetch queue; master is the queue itself, slave is its environment.
interface instr_prefetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             out_valid;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc4;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc4, count
    );

    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc4, count
    );

endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {instruction, PC+4}; flush empties it
// in one cycle and the head reads as zero while empty.
module prefetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] head,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    // NOTE: storage is deliberately left unreset; count and pointers define what is valid.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front-end: one outstanding sequential fetch at a time, results queued
// for decode, EX/MEM redirect flushes the queue and restarts at the target.
module instr_prefetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic                  Clk,
    input logic                  Rst,
    instr_prefetch_queue_if.master bus
);

    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [1:0]       state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_addr;
    logic [31:0]      next_addr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] occ_next;
    logic             ack;
    logic             push;
    logic             pop;
    entry_t           wdata;
    entry_t           head;

    // An ack only counts while a request is actually being presented.
    assign ack       = bus.imem_ack && (state != IDLE);
    assign push      = (state == FETCH) && ack && !bus.redirect;
    assign pop       = bus.out_valid && bus.out_ready && !bus.redirect;
    assign next_addr = req_addr + 32'd4;
    assign occ_next  = count + CNT_W'(push) - CNT_W'(pop);
    assign wdata     = '{instr: bus.imem_rdata, pc4: next_addr};

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            // A request still waiting for memory must be drained before the new one.
            if (state == IDLE || ack) begin
                state    <= FETCH;
                req_addr <= bus.redirect_pc;
            end else begin
                state <= DISCARD;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state    <= FETCH;
                        req_addr <= fetch_pc;
                    end
                end
                FETCH: begin
                    if (ack) begin
                        fetch_pc <= next_addr;
                        if (occ_next < FULL) req_addr <= next_addr;
                        else                 state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state    <= FETCH;
                        req_addr <= fetch_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state == FETCH) || (state == DISCARD);
    assign bus.imem_addr = req_addr;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc4   = head.pc4;
    assign bus.count     = count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: the memory responder predicts the
// delivered instruction stream, a separate monitor checks what decode receives.
module tb_instr_prefetch_queue;
    import mips_fetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_next;
    bit          push_pending;
    bit          mon_en = 1'b0;
    bit          saw_wrap = 1'b0;
    logic [31:0] last_pc4;

    // memory responder state
    bit          waiting;
    bit          last_ack;
    int          wait_left;
    logic [31:0] held_addr;
    int          lat_fixed;
    bit          lat_rand;
    int          ready_mode;
    logic [31:0] region;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: memory responder, decode ready, optional redirect.
    // Every accepted fetch of the next expected address becomes an expectation.
    task automatic cycle(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
        bit   ack;
        exp_t t;
        @(negedge clk);
        ack = 1'b0;
        if (bus.imem_req) begin
            if (!waiting) begin
                waiting   = 1'b1;
                held_addr = bus.imem_addr;
                wait_left = lat_rand ? int'($urandom_range(3, 0)) : lat_fixed;
            end else begin
                check("addr_held", bus.imem_addr, held_addr);
            end
            if (wait_left == 0) ack = 1'b1;
            else                wait_left--;
        end
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? mem_word(held_addr) : $urandom;
        bus.out_ready   = (ready_mode == 2) ? 1'($urandom_range(1, 0)) : (ready_mode == 1);
        bus.redirect    = redir;
        bus.redirect_pc = redir ? tgt : $urandom;
        push_pending = 1'b0;
        if (redir) begin
            exp_next = tgt;
        end else if (ack && held_addr == exp_next) begin
            t.instr = mem_word(held_addr);
            t.pc4   = held_addr + 32'd4;
            exp_q.push_back(t);
            exp_next     = exp_next + 32'd4;
            push_pending = 1'b1;
        end
        if (ack) waiting = 1'b0;
        last_ack = ack;
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("rst_req",   32'(bus.imem_req),  32'd0);
            check("rst_addr",  bus.imem_addr,       RST_PC);
            check("rst_valid", 32'(bus.out_valid), 32'd0);
            check("rst_count", 32'(bus.count),     32'd0);
            check("rst_instr", bus.out_instr,       32'd0);
            check("rst_pc4",   bus.out_pc4,         32'd0);
        end
        exp_q.delete();
        exp_next     = RST_PC;
        waiting      = 1'b0;
        push_pending = 1'b0;
        last_ack     = 1'b0;
        rst = 1'b1;
    endtask

    task automatic run_until_req(input logic [31:0] a, input string name);
        int i = 0;
        do begin
            cycle();
            i++;
        end while (!(waiting && held_addr == a && wait_left > 0) && i < 200);
        check(name, held_addr, a);
    endtask

    task automatic run_until_delivery(input string name, input logic [31:0] pc4);
        int d0 = n_deliv;
        int i  = 0;
        while (n_deliv == d0 && i < 60) begin
            cycle();
            i++;
        end
        check(name, last_pc4, pc4);
    endtask

    // Monitor: checks occupancy and every instruction handed to decode.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mon_en && rst) begin
            if (bus.redirect) begin
                exp_q.delete();
            end else begin
                check("count", 32'(bus.count), 32'(exp_q.size()) - 32'(push_pending));
                check("out_valid", 32'(bus.out_valid),
                      32'((32'(exp_q.size()) - 32'(push_pending)) != 0));
                if (int'(bus.count) == DEPTH) check("no_req_when_full", 32'(bus.imem_req), 32'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_delivery @%0t: got pc4 0x%08h, expected none", $time, bus.out_pc4);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", bus.out_instr, e.instr);
                        check("pc4",   bus.out_pc4,   e.pc4);
                        if (e.pc4 == 32'd0) saw_wrap = 1'b1;
                    end
                    last_pc4 = bus.out_pc4;
                    n_deliv++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog @%0t: got timeout, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b0;
        bus.imem_ack = 1'b0;  bus.imem_rdata = '0;
        bus.redirect = 1'b0;  bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        waiting = 1'b0; last_ack = 1'b0; wait_left = 0; held_addr = '0;
        lat_fixed = 0; lat_rand = 1'b0; ready_mode = 1;
        region = 32'h1000_0000; last_pc4 = '0; exp_next = RST_PC; push_pending = 1'b0;

        // Reset state, then zero-wait latency and throughput.
        do_reset(1'b1);
        mon_en = 1'b1;
        cycle();
        check("lat_req_c1",   32'(bus.imem_req),  32'd1);
        check("lat_addr_c1",  bus.imem_addr,       RST_PC);
        check("lat_valid_c1", 32'(bus.out_valid), 32'd0);
        cycle();
        check("lat_valid_c2", 32'(bus.out_valid), 32'd1);
        check("lat_pc4_c2",   bus.out_pc4,         RST_PC + 32'd4);
        d0 = n_deliv;
        repeat (20) cycle();
        check("throughput", 32'(n_deliv - d0), 32'd20);

        // Decode stalled: queue fills, fetch stops, one pop re-arms fetch at 16.
        ready_mode = 0;
        do_reset(1'b0);
        repeat (6) cycle();
        check("full_count", 32'(bus.count),    32'(DEPTH));
        check("full_req",   32'(bus.imem_req), 32'd0);
        ready_mode = 1;
        cycle();
        ready_mode = 0;
        cycle();
        check("one_pop_count", 32'(bus.count),    32'(DEPTH - 1));
        check("one_pop_req",   32'(bus.imem_req), 32'd0);
        cycle();
        check("refetch_req",  32'(bus.imem_req), 32'd1);
        check("refetch_addr", bus.imem_addr,      RST_PC + 32'd16);

        // Slow memory: redirect while the fetch of address 8 is outstanding.
        ready_mode = 1; lat_fixed = 3;
        do_reset(1'b0);
        run_until_req(RST_PC + 32'd8, "wait_req_8");
        cycle(1'b1, 32'h0000_0100);
        cycle();
        check("discard_req",  32'(bus.imem_req), 32'd1);
        check("discard_addr", bus.imem_addr,      RST_PC + 32'd8);
        run_until_delivery("redirect_first_pc4", 32'h0000_0104);

        // Redirect coinciding with an ack and a pending pop.
        lat_fixed = 0;
        do_reset(1'b0);
        repeat (5) cycle();
        cycle(1'b1, 32'h0000_0400);
        cycle();
        check("flush_count", 32'(bus.count),    32'd0);
        check("flush_req",   32'(bus.imem_req), 32'd1);
        check("flush_addr",  bus.imem_addr,      32'h0000_0400);
        run_until_delivery("flush_first_pc4", 32'h0000_0404);
        repeat (6) cycle();

        // Two redirects while draining a stale request: the latest one wins.
        lat_fixed = 3;
        do_reset(1'b0);
        cycle();
        cycle(1'b1, 32'h0000_0200);
        cycle(1'b1, 32'h0000_0300);
        for (int i = 0; i < 10 && !last_ack; i++) cycle();
        cycle();
        check("latest_redirect_addr", bus.imem_addr, 32'h0000_0300);
        run_until_delivery("latest_redirect_pc4", 32'h0000_0304);

        // Reset while a request is outstanding, ack arrives the cycle after.
        do_reset(1'b0);
        cycle();
        cycle();
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("midrst_req",   32'(bus.imem_req),  32'd0);
        check("midrst_count", 32'(bus.count),     32'd0);
        check("midrst_addr",  bus.imem_addr,       RST_PC);
        exp_q.delete();
        exp_next = RST_PC; waiting = 1'b0; push_pending = 1'b0; last_ack = 1'b0;
        rst = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        cycle();
        check("restart_req",   32'(bus.imem_req), 32'd1);
        check("restart_addr",  bus.imem_addr,      RST_PC);
        check("restart_count", 32'(bus.count),    32'd0);
        run_until_delivery("restart_first_pc4", RST_PC + 32'd4);

        // 32-bit wrap of the fetch PC.
        lat_fixed = 0; ready_mode = 1;
        cycle(1'b1, 32'hFFFF_FFF0);
        repeat (8) cycle();
        check("pc_wrap_seen", 32'(saw_wrap), 32'd1);

        // Random latency, stalls and redirects into fresh address regions.
        lat_rand = 1'b1; ready_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24, 0) == 0) begin
                cycle(1'b1, region);
                region = region + 32'h0001_0000;
            end else begin
                cycle();
            end
        end
        check("random_progress", 32'(n_deliv > 500), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
